handshake_const_check: RTL and testbench
========================================

HANDSHAKE_CONST_CHECK -- requirements
Module: handshake_const_check

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of the input data token.
REQ-002 The block SHALL have parameter CONST_VALUE, default 17 (6'b010001), giving the expected token value, zero-extended to DATA_WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port ins, input, DATA_WIDTH bits: the input data token.
REQ-006 The block SHALL have port ins_valid, input, 1 bit: an input token is offered.
REQ-007 The block SHALL have port ins_ready, output, 1 bit: the block can accept a token.
REQ-008 The block SHALL have port ctrl_valid, output, 1 bit: an output control token (dataless) is offered.
REQ-009 The block SHALL have port ctrl_ready, input, 1 bit: the downstream stage accepts the control token.
REQ-010 The block SHALL have port mismatch, output, 1 bit: sticky flag, set once any consumed token differed from CONST_VALUE.
REQ-011 The block SHALL have port err_count, output, 16 bits: saturating count of mismatching tokens consumed.

Function
REQ-012 The block SHALL hold input tokens in a 2-entry FIFO; a push occurs on ins_valid && ins_ready.
REQ-013 ins_ready SHALL be 1 exactly when the FIFO holds fewer than 2 entries, from registered occupancy only, with no combinational path from ctrl_ready.
REQ-014 When the FIFO is full, a pop and an offered input in the same cycle SHALL NOT accept the input that cycle; ins_ready rises the following cycle.
REQ-015 ctrl_valid SHALL be 1 exactly when the FIFO is non-empty (macro-off behaviour); a pop occurs on ctrl_valid && ctrl_ready.
REQ-016 Latency SHALL be one cycle: a token pushed in cycle N raises ctrl_valid in cycle N+1 if the FIFO was empty.
REQ-017 A simultaneous push and pop with 1 entry SHALL leave occupancy at 1 and preserve order.
REQ-018 ctrl_valid SHALL remain asserted without dropping until its handshake completes.
REQ-019 Each token SHALL be compared to CONST_VALUE when it leaves the FIFO (pop or drop).
REQ-020 On a mismatching departure, mismatch SHALL be set and err_count incremented by 1, saturating at 16'hFFFF.
REQ-021 mismatch SHALL stay set until reset.
REQ-022 Order SHALL be preserved: tokens leave in arrival order.

Reset
REQ-023 While rst is 0 at a rising clk edge, FIFO occupancy, mismatch and err_count SHALL clear to 0.
REQ-024 During reset and in the first cycle after it, ins_ready SHALL be 1 and ctrl_valid SHALL be 0.
REQ-025 Reset mid-transfer SHALL discard all buffered tokens with no counting.

Configuration
REQ-026 Macro HANDSHAKE_CONST_CHECK_DROP_EN SHALL select drop mode.
REQ-027 With the macro defined, ctrl_valid SHALL be 1 only when the FIFO head equals CONST_VALUE; a mismatching head SHALL be removed internally in the cycle it is at the head, independent of ctrl_ready, and counted per REQ-020.
REQ-028 Without the macro, every token SHALL be forwarded as a control token per REQ-015.

Structure
REQ-029 Package handshake_pkg SHALL hold the FIFO depth constant (2) and the err_count width constant (16).
REQ-030 The FIFO SHALL be the sub-module handshake_fifo2, with a valid/ready push side and a valid/ready pop side, parameterised by DATA_WIDTH.

Verification
REQ-031 Reset, then push ins=17 in cycle 1 with ctrl_ready=1 -> ctrl_valid=1 in cycle 2, popped; mismatch=0, err_count=0.
REQ-032 ctrl_ready=0, push 17, 17, 17 back-to-back -> first two accepted, ins_ready=0 after the second, third held until ctrl_ready=1.
REQ-033 Push 17 then 5 with ctrl_ready=1, macro off -> two control tokens; mismatch=1 and err_count=1 after the second pop.
REQ-034 Same stimulus with HANDSHAKE_CONST_CHECK_DROP_EN -> one control token; the 5 is dropped; err_count=1.
REQ-035 Preload err_count to 16'hFFFE via 3 mismatches forced through a backdoor, then 3 more mismatches -> count holds at 16'hFFFF.
REQ-036 Assert rst=0 with 2 tokens buffered -> next cycle ctrl_valid=0, ins_ready=1, err_count=0.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared constants for the handshake constant checker: FIFO depth, error counter width,
// and a saturating increment helper.
package handshake_pkg;

   localparam int unsigned FifoDepth   = 2;
   localparam int unsigned ErrCntWidth = 16;
   localparam int unsigned PtrWidth    = $clog2(FifoDepth);
   localparam int unsigned OccWidth    = $clog2(FifoDepth + 1);

   function automatic logic [ErrCntWidth-1:0] sat_inc(input logic [ErrCntWidth-1:0] val);
      return (&val) ? val : val + ErrCntWidth'(1);
   endfunction

endpackage

// File: rtl/handshake_fifo2.sv
// Two-entry valid/ready FIFO. push_ready_o comes from registered occupancy only, so a full FIFO
// does not accept a new token in the same cycle as a pop.
module handshake_fifo2
   import handshake_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  push_valid_i,
   output logic                  push_ready_o,
   output logic [DATA_WIDTH-1:0] pop_data_o,
   output logic                  pop_valid_o,
   input  logic                  pop_ready_i
);

   logic [DATA_WIDTH-1:0] mem_q [FifoDepth];
   logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
   logic [OccWidth-1:0]   occ_q, occ_d;
   logic                  push, pop;

   assign push_ready_o = (occ_q < OccWidth'(FifoDepth));
   assign pop_valid_o  = (occ_q != '0);
   assign pop_data_o   = mem_q[rd_ptr_q];

   assign push = push_valid_i && push_ready_o;
   assign pop  = pop_valid_o && pop_ready_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrWidth'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrWidth'(1);
      end
      if (push && !pop) begin
         occ_d = occ_q + OccWidth'(1);
      end else if (pop && !push) begin
         occ_d = occ_q - OccWidth'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/handshake_const_check.sv
// Buffers tokens in a 2-entry FIFO, forwards each as a dataless control token and counts those
// that differ from CONST_VALUE. Define HANDSHAKE_CONST_CHECK_DROP_EN to drop mismatching tokens.
module handshake_const_check
   import handshake_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned CONST_VALUE = 17
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_WIDTH-1:0]  ins,
   input  logic                   ins_valid,
   output logic                   ins_ready,
   output logic                   ctrl_valid,
   input  logic                   ctrl_ready,
   output logic                   mismatch,
   output logic [ErrCntWidth-1:0] err_count
);

   localparam logic [DATA_WIDTH-1:0] ConstTok = DATA_WIDTH'(CONST_VALUE);

   logic [DATA_WIDTH-1:0]  head_data;
   logic                   head_valid;
   logic                   head_match;
   logic                   head_pop_req;
   logic                   depart;
   logic                   mismatch_q, mismatch_d;
   logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;

   handshake_fifo2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk_i        (clk),
      .rst_ni       (rst),
      .push_data_i  (ins),
      .push_valid_i (ins_valid),
      .push_ready_o (ins_ready),
      .pop_data_o   (head_data),
      .pop_valid_o  (head_valid),
      .pop_ready_i  (head_pop_req)
   );

   assign head_match = (head_data == ConstTok);

`ifdef HANDSHAKE_CONST_CHECK_DROP_EN
   // A mismatching head leaves on its own, whatever ctrl_ready does.
   assign ctrl_valid   = head_valid && head_match;
   assign head_pop_req = ctrl_ready || !head_match;
`else
   assign ctrl_valid   = head_valid;
   assign head_pop_req = ctrl_ready;
`endif

   assign depart = head_valid && head_pop_req;

   always_comb begin
      mismatch_d = mismatch_q;
      err_cnt_d  = err_cnt_q;
      if (depart && !head_match) begin
         mismatch_d = 1'b1;
         err_cnt_d  = sat_inc(err_cnt_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mismatch_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         mismatch_q <= mismatch_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign mismatch  = mismatch_q;
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_handshake_const_check.sv
// Directed bench for handshake_const_check: a queue-based reference model checked every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_handshake_const_check;

   localparam int unsigned K = 17;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ins;
   logic        ins_valid;
   logic        ins_ready;
   logic        ctrl_valid;
   logic        ctrl_ready;
   logic        mismatch;
   logic [15:0] err_count;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned dut_tokens = 0;

   logic [31:0] m_q[$];
   logic        m_mis = 1'b0;
   logic [15:0] m_cnt = 16'h0;
   logic        m_live = 1'b0;
   logic        force_active = 1'b0;

   always #5 clk = ~clk;

   handshake_const_check dut (
      .clk        (clk),
      .rst        (rst),
      .ins        (ins),
      .ins_valid  (ins_valid),
      .ins_ready  (ins_ready),
      .ctrl_valid (ctrl_valid),
      .ctrl_ready (ctrl_ready),
      .mismatch   (mismatch),
      .err_count  (err_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One clock cycle: compare DUT against the model mid-cycle, advance the model with this
   // cycle's inputs, then return just after the next rising edge.
   task automatic tick();
      logic exp_cv;
      logic push;
      logic leave;
      logic match;
      @(negedge clk);
      if (force_active) m_cnt = 16'hFFFB;
      if (m_live) begin
         exp_cv = (m_q.size() != 0);
`ifdef HANDSHAKE_CONST_CHECK_DROP_EN
         if (exp_cv) exp_cv = (m_q[0] == K);
`endif
         check("model_ins_ready", {31'b0, ins_ready}, {31'b0, m_q.size() < 2});
         check("model_ctrl_valid", {31'b0, ctrl_valid}, {31'b0, exp_cv});
         check("model_mismatch", {31'b0, mismatch}, {31'b0, m_mis});
         check("model_err_count", {16'b0, err_count}, {16'b0, m_cnt});
      end
      if (rst && ctrl_valid && ctrl_ready) dut_tokens++;
      if (!rst) begin
         m_q.delete();
         m_mis  = 1'b0;
         m_cnt  = 16'h0;
         m_live = 1'b1;
      end else if (m_live) begin
         push  = ins_valid && (m_q.size() < 2);
         leave = 1'b0;
         match = 1'b0;
         if (m_q.size() != 0) begin
            match = (m_q[0] == K);
`ifdef HANDSHAKE_CONST_CHECK_DROP_EN
            leave = ctrl_ready || !match;
`else
            leave = ctrl_ready;
`endif
         end
         if (leave) begin
            if (!match) begin
               m_mis = 1'b1;
               if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
            end
            void'(m_q.pop_front());
         end
         if (push) m_q.push_back(ins);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic burst(input logic [31:0] value, input int n);
      ins       = value;
      ins_valid = 1'b1;
      repeat (n) tick();
      ins_valid = 1'b0;
      repeat (2) tick();
   endtask

   initial begin
      rst        = 1'b0;
      ins        = 32'h0;
      ins_valid  = 1'b0;
      ctrl_ready = 1'b0;
      tick();
      check("reset_ins_ready", {31'b0, ins_ready}, 32'd1);
      check("reset_ctrl_valid", {31'b0, ctrl_valid}, 32'd0);
      check("reset_err_count", {16'b0, err_count}, 32'd0);
      tick();
      rst = 1'b1;

      // Single matching token, one-cycle latency.
      dut_tokens = 0;
      ins        = K;
      ins_valid  = 1'b1;
      ctrl_ready = 1'b1;
      tick();
      ins_valid = 1'b0;
      check("t1_latency_ctrl_valid", {31'b0, ctrl_valid}, 32'd1);
      tick();
      check("t1_drained", {31'b0, ctrl_valid}, 32'd0);
      check("t1_mismatch", {31'b0, mismatch}, 32'd0);
      check("t1_tokens", dut_tokens, 32'd1);

      // Backpressure: two accepted, third held until downstream opens.
      dut_tokens = 0;
      ctrl_ready = 1'b0;
      ins        = K;
      ins_valid  = 1'b1;
      tick();
      check("t2_one_ready", {31'b0, ins_ready}, 32'd1);
      tick();
      check("t2_full", {31'b0, ins_ready}, 32'd0);
      tick();
      check("t2_still_full", {31'b0, ins_ready}, 32'd0);
      ctrl_ready = 1'b1;
      tick();
      check("t2_reopen", {31'b0, ins_ready}, 32'd1);
      tick();
      ins_valid = 1'b0;
      repeat (2) tick();
      check("t2_tokens", dut_tokens, 32'd3);
      check("t2_err_count", {16'b0, err_count}, 32'd0);

      // 17 then 5.
      dut_tokens = 0;
      ins        = K;
      ins_valid  = 1'b1;
      tick();
      ins = 32'd5;
      tick();
      ins_valid = 1'b0;
      check("t3_before_mismatch", {31'b0, mismatch}, 32'd0);
      tick();
      check("t3_mismatch", {31'b0, mismatch}, 32'd1);
      check("t3_err_count", {16'b0, err_count}, 32'd1);
      tick();
`ifdef HANDSHAKE_CONST_CHECK_DROP_EN
      check("t3_tokens", dut_tokens, 32'd1);
`else
      check("t3_tokens", dut_tokens, 32'd2);
`endif

      // Saturation: preload via backdoor, then push mismatches past the limit.
      force dut.err_cnt_q = 16'hFFFB;
      force_active = 1'b1;
      tick();
      release dut.err_cnt_q;
      force_active = 1'b0;
      burst(32'd5, 3);
      check("t4_preloaded", {16'b0, err_count}, 32'h0000FFFE);
      burst(32'd5, 3);
      check("t4_saturated", {16'b0, err_count}, 32'h0000FFFF);
      check("t4_mismatch", {31'b0, mismatch}, 32'd1);

      // Reset with two tokens buffered.
      ctrl_ready = 1'b0;
      ins        = K;
      ins_valid  = 1'b1;
      tick();
      ins = 32'd5;
      tick();
      ins_valid = 1'b0;
      check("t5_full", {31'b0, ins_ready}, 32'd0);
      check("t5_head_valid", {31'b0, ctrl_valid}, 32'd1);
      rst = 1'b0;
      tick();
      check("t5_rst_ctrl_valid", {31'b0, ctrl_valid}, 32'd0);
      check("t5_rst_ins_ready", {31'b0, ins_ready}, 32'd1);
      check("t5_rst_err_count", {16'b0, err_count}, 32'd0);
      check("t5_rst_mismatch", {31'b0, mismatch}, 32'd0);
      rst        = 1'b1;
      ctrl_ready = 1'b1;
      repeat (2) tick();
      check("t5_discarded_valid", {31'b0, ctrl_valid}, 32'd0);
      check("t5_discarded_count", {16'b0, err_count}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
